muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_if.sv | 33 +++
 rtl/muldiv_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the EX-stage control and the mul/div sequencer.
// Latency: none; this interface is wiring only.
// Backpressure: stall is driven back to the pipeline through this bundle.
interface muldiv_sequencer_if;
   // Pipeline -> sequencer
   logic       valid;
   logic       is_mul;
   logic       is_div;
   logic       is_mod;
   logic [3:0] rd;
   logic       flush;
   // Sequencer -> unit / pipeline / writeback
   logic       unit_start;
   logic [1:0] unit_op;
   logic       unit_abort;
   logic       stall;
   logic       wb_en;
   logic [3:0] wb_rd;
   logic       busy;
   logic [5:0] count;

   // Pipeline/control side
   modport master (
      output valid, is_mul, is_div, is_mod, rd, flush,
      input  unit_start, unit_op, unit_abort, stall, wb_en, wb_rd, busy, count
   );

   // Sequencer side
   modport slave (
      input  valid, is_mul, is_div, is_mod, rd, flush,
      output unit_start, unit_op, unit_abort, stall, wb_en, wb_rd, busy, count
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences a multi-cycle mul/div/mod op: start pulse, busy countdown, one-cycle writeback.
// Latency: writeback LAT+1 cycles after accept (LAT = MUL_LAT or DIV_LAT).
// Backpressure: stall held from the accept cycle through the last BUSY cycle; dropped in DONE or on flush.
module muldiv_sequencer #(
   parameter int unsigned MUL_LAT = 4,   // busy cycles for a multiply, 1..63
   parameter int unsigned DIV_LAT = 32   // busy cycles for divide/modulus, 1..63
) (
   input  logic               clk,
   input  logic               rst,
   muldiv_sequencer_if.slave  bus
);

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_DIV = 2'b01;
   localparam logic [1:0] OP_MOD = 2'b10;

   // Countdown start values: BUSY runs while count goes LAT-1 .. 0
   localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] count_q, count_d;
   logic [1:0] op_q,    op_d;
   logic [3:0] rd_q,    rd_d;

   logic       any_op;
   logic       accept;
   logic [1:0] op_enc;
   logic [5:0] load_cnt;
   logic       start_raw;
   logic       abort_raw;
   logic       stall_raw;
   logic       wb_en_raw;

   // Decode the requested op; div outranks mod, which outranks mul
   always_comb begin
      op_enc   = OP_MUL;
      load_cnt = MUL_CNT;
      if (bus.is_div) begin
         op_enc   = OP_DIV;
         load_cnt = DIV_CNT;
      end else if (bus.is_mod) begin
         op_enc   = OP_MOD;
         load_cnt = DIV_CNT;
      end
   end

   // A new op is taken only from IDLE and never alongside a flush or during reset
   assign any_op = bus.is_mul | bus.is_div | bus.is_mod;
   assign accept = bus.valid & any_op & ~bus.flush & (state_q == S_IDLE) & ~rst;

   // Next-state and per-state control outputs
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_d      = op_q;
      rd_d      = rd_q;
      start_raw = 1'b0;
      abort_raw = 1'b0;
      stall_raw = 1'b0;
      wb_en_raw = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               start_raw = 1'b1;
               stall_raw = 1'b1;
               op_d      = op_enc;
               rd_d      = bus.rd;
               count_d   = load_cnt;
               state_d   = S_BUSY;
            end
         end

         S_BUSY: begin
            if (bus.flush) begin
               // Killed op: tell the unit to drop it and release the pipeline now
               abort_raw = 1'b1;
               count_d   = 6'd0;
               state_d   = S_IDLE;
            end else begin
               stall_raw = 1'b1;
               if (count_q == 6'd0) begin
                  state_d = S_DONE;
               end else begin
                  count_d = count_q - 6'd1;
               end
            end
         end

         S_DONE: begin
            // Result is ready; a flush here suppresses the writeback. Never accepts.
            wb_en_raw = ~bus.flush;
            state_d   = S_IDLE;
         end

         default: begin
            count_d = 6'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, countdown and latched op/rd registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= 6'd0;
         op_q    <= OP_MUL;
         rd_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
      end
   end

   // Outputs are forced low while reset is held so the pipeline sees a quiet block immediately
   assign bus.unit_start = start_raw & ~rst;
   assign bus.unit_abort = abort_raw & ~rst;
   assign bus.stall      = stall_raw & ~rst;
   assign bus.wb_en      = wb_en_raw & ~rst;
   assign bus.busy       = (state_q != S_IDLE) & ~rst;
   // The unit sees the new op code in the accept cycle, before it is latched
   assign bus.unit_op    = accept ? op_enc : op_q;
   assign bus.wb_rd      = rd_q;
   assign bus.count      = count_q;

endmodule
